// File: rtl/mux_n_pipe.sv
// mux_n_pipe: parametrised N-to-1 data multiplexer followed by a 2-entry
// valid/ready skid buffer. The selected input is captured together with the
// select on every accepted transfer and appears on out_* one cycle later.
// No combinational path exists from in_* to out_*, and in_ready is a flop,
// so the consumer's out_ready never times through to the producer.
//
// Parameters:
//   WIDTH   data width per input and output
//   NUM_IN  number of inputs (2..16)
//   SEL_W   select width, derived from NUM_IN
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all buffered entries (beats accept/pop)
//   in_data    flattened inputs, input k at [k*WIDTH +: WIDTH]
//   sel        binary select, sampled on accept
//   in_valid   upstream has a transfer
//   in_ready   block can accept a transfer
//   out_data   data of the head entry
//   out_valid  head entry valid
//   out_ready  downstream accepts the head
//   sel_err    head entry was captured with an out-of-range select
//              (only when MUX_SEL_CHECK_EN is defined)
//
// Optional feature macro: MUX_SEL_CHECK_EN
module mux_n_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   main_data;
  logic [WIDTH-1:0]   skid_data;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   cap_data;
  logic               sel_hit;
  logic               accept;
  logic               pop;

  // An unmatched select (only possible for non-power-of-two NUM_IN) leaves
  // cap_data at zero and sel_hit low.
  always_comb begin
    cap_data = '0;
    sel_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_data   <= '0;
      skid_data   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data   <= cap_data;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid_data  <= cap_data;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (accept && pop) begin
            main_data <= cap_data;
          end else if (pop) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_data  <= skid_data;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic main_err;
  logic skid_err;

  // Flags follow exactly the same load pattern as main_data/skid_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_err <= 1'b0;
      skid_err <= 1'b0;
    end else if (flush) begin
      main_err <= 1'b0;
      skid_err <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) main_err <= !sel_hit;
        ONE: begin
          if (accept && !pop)     skid_err <= !sel_hit;
          else if (accept && pop) main_err <= !sel_hit;
        end
        FULL: if (pop) main_err <= skid_err;
        default: begin
          main_err <= 1'b0;
          skid_err <= 1'b0;
        end
      endcase
    end
  end

  assign sel_err = main_err && out_valid_q;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
module tb_mux_n_pipe;

  logic         clk = 1'b0;
  logic         rst_n;

  // NUM_IN=4 instance
  logic         flush;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
`ifdef MUX_SEL_CHECK_EN
  logic         sel_err;
`endif

  // NUM_IN=3 instance (out-of-range select)
  logic         flush3;
  logic [95:0]  in_data3;
  logic [1:0]   sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  out_data3;
  logic         out_valid3;
  logic         out_ready3;
`ifdef MUX_SEL_CHECK_EN
  logic         sel_err3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(sel_err)
`endif
  );

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(sel_err3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_data    = '0;
    sel        = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    flush3     = 1'b0;
    in_data3   = '0;
    sel3       = '0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;

    // 1. reset values, then one basic select
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid3", {31'b0, out_valid3}, 32'd0);
`ifdef MUX_SEL_CHECK_EN
    check("rst_sel_err", {31'b0, sel_err}, 32'd0);
`endif
    rst_n = 1'b1;

    in_data   = {32'h33, 32'h22, 32'h11, 32'h00};
    sel       = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("basic_valid", {31'b0, out_valid}, 32'd1);
    check("basic_data", out_data, 32'h22);
    tick();
    check("basic_drain", {31'b0, out_valid}, 32'd0);

    // 2. backpressure fill then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    tick();
    check("bp_one_ready", {31'b0, in_ready}, 32'd1);
    check("bp_one_data", out_data, 32'h11);
    sel = 2'd3;
    tick();
    in_valid = 1'b0;
    check("bp_full_ready", {31'b0, in_ready}, 32'd0);
    check("bp_full_data", out_data, 32'h11);
    check("bp_full_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("bp_hold_data", out_data, 32'h11);
    out_ready = 1'b1;
    tick();
    check("bp_pop2_data", out_data, 32'h33);
    check("bp_pop2_valid", {31'b0, out_valid}, 32'd1);
    check("bp_pop2_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp_empty_valid", {31'b0, out_valid}, 32'd0);
    check("bp_empty_ready", {31'b0, in_ready}, 32'd1);

    // 3. streaming with changing data and select
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'hA000 + 32'(i*16 + k);
      sel      = 2'(i % 4);
      in_valid = 1'b1;
      tick();
      check("stream_valid", {31'b0, out_valid}, 32'd1);
      check("stream_data", out_data, 32'hA000 + 32'(i*16 + (i % 4)));
      check("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", {31'b0, out_valid}, 32'd0);

    // 4. flush from FULL with a transfer presented
    in_data   = {32'h33, 32'h22, 32'h11, 32'h00};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    tick();
    sel = 2'd2;
    tick();
    check("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    sel   = 2'd0;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("fl_valid", {31'b0, out_valid}, 32'd0);
    check("fl_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("fl_nothing1", {31'b0, out_valid}, 32'd0);
    tick();
    check("fl_nothing2", {31'b0, out_valid}, 32'd0);
    // flush from ONE while a transfer is presented: it is dropped
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd3;
    tick();
    flush = 1'b1;
    sel   = 2'd0;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("fl1_drop", {31'b0, out_valid}, 32'd0);

    // 5. asynchronous reset while in ONE
    in_valid = 1'b1;
    sel      = 2'd3;
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_data", out_data, 32'd0);
    check("ar_ready", {31'b0, in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ar_lost", {31'b0, out_valid}, 32'd0);

    // 6. out-of-range select on NUM_IN=3
    in_data3   = {32'h22, 32'h11, 32'h00};
    out_ready3 = 1'b1;
    in_valid3  = 1'b1;
    sel3       = 2'd2;
    tick();
    in_valid3 = 1'b0;
    check("oor_max_data", out_data3, 32'h22);
    tick();
    check("oor_max_drain", {31'b0, out_valid3}, 32'd0);
    out_ready3 = 1'b0;
    in_valid3  = 1'b1;
    sel3       = 2'd3;
    tick();
    check("oor_head_valid", {31'b0, out_valid3}, 32'd1);
    check("oor_head_data", out_data3, 32'd0);
`ifdef MUX_SEL_CHECK_EN
    check("oor_head_err", {31'b0, sel_err3}, 32'd1);
`endif
    sel3 = 2'd1;
    tick();
    in_valid3 = 1'b0;
    check("oor_full", {31'b0, in_ready3}, 32'd0);
    check("oor_full_data", out_data3, 32'd0);
`ifdef MUX_SEL_CHECK_EN
    check("oor_full_err", {31'b0, sel_err3}, 32'd1);
`endif
    out_ready3 = 1'b1;
    tick();
    check("oor_pop_data", out_data3, 32'h11);
    check("oor_pop_valid", {31'b0, out_valid3}, 32'd1);
`ifdef MUX_SEL_CHECK_EN
    check("oor_pop_err", {31'b0, sel_err3}, 32'd0);
`endif
    tick();
    check("oor_drain", {31'b0, out_valid3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
